// File: rtl/rv32m_muldiv_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM states and default widths.
package muldiv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the ID/EX register, hazard unit and the
// multiply/divide unit.
interface rv32m_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, rs1_val, rs2_val,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, rs1_val, rs2_val,
        output busy, done, result
    );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, followed by one sign-fix cycle.
module rv32m_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    rv32m_muldiv_unit_if.slave bus
);

    state_e              state, state_nxt;
    funct3_e             op;
    logic                negate;
    logic [XLEN-1:0]     b_mag;
    logic [2*XLEN-1:0]   acc;
    logic [CNT_W-1:0]    cnt;
    logic [XLEN-1:0]     result_q;

    // Launch-time decode of the incoming request
    funct3_e         f3_in;
    logic            a_signed, b_signed, sa, sb;
    logic            div_zero, div_ovf, special, can_launch;
    logic [XLEN-1:0] a_mag_in, b_mag_in, special_val;

    assign f3_in    = funct3_e'(bus.funct3);
    assign a_signed = f3_in inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    assign b_signed = f3_in inside {F3_MULH, F3_DIV, F3_REM};
    assign sa       = a_signed & bus.rs1_val[XLEN-1];
    assign sb       = b_signed & bus.rs2_val[XLEN-1];
    assign a_mag_in = sa ? -bus.rs1_val : bus.rs1_val;
    assign b_mag_in = sb ? -bus.rs2_val : bus.rs2_val;

    assign div_zero = bus.funct3[2] && (bus.rs2_val == '0);
    assign div_ovf  = (f3_in inside {F3_DIV, F3_REM})
                   && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.rs2_val == '1);
    assign special  = div_zero || div_ovf;

    // funct3[1] separates REM/REMU from DIV/DIVU; overflow quotient equals rs1
    assign special_val = bus.funct3[1] ? (div_zero ? bus.rs1_val : '0)
                                       : (div_zero ? '1 : bus.rs1_val);

    assign can_launch = (state == IDLE || state == DONE) && bus.start && !bus.flush;

    // One radix-2 step: acc is {hi, lo} for multiply, {remainder, quotient} for divide
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] step_acc;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag};
        div_ge    = ~div_diff[XLEN];
        if (op[2])
            step_acc = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc[XLEN-2:0], div_ge};
        else
            step_acc = {mul_sum, acc[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_val, fix_val;

    always_comb begin
        prod    = negate ? -acc : acc;
        div_val = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (op[2])
            fix_val = negate ? -div_val : div_val;
        else if (op == F3_MUL)
            fix_val = prod[XLEN-1:0];
        else
            fix_val = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next-state defaults to the current state before the case so every path assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (can_launch) state_nxt = special ? DONE : CALC;
                else            state_nxt = IDLE;
            end
            CALC: begin
                if (bus.flush)                         state_nxt = IDLE;
                else if (cnt == CNT_W'(XLEN-1))        state_nxt = FIX;
            end
            FIX: state_nxt = bus.flush ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op       <= F3_MUL;
            negate   <= 1'b0;
            b_mag    <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (can_launch) begin
                        op     <= f3_in;
                        negate <= (f3_in inside {F3_REM, F3_REMU}) ? sa : (sa ^ sb);
                        b_mag  <= b_mag_in;
                        acc    <= {{XLEN{1'b0}}, a_mag_in};
                        cnt    <= '0;
                        if (special) result_q <= special_val;
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        acc <= step_acc;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!bus.flush) result_q <= fix_val;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == CALC) || (state == FIX);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

endmodule
